// File: rtl/alarm_controller.sv
// alarm_controller
//   Compares the running time from the hour/minute/second counter chain with
//   the user alarm time. Runs the alarm state machine: arm, ring, snooze,
//   stop and auto-silence. Drives the buzzer and the alarm LED.
//
// Ports
//   clk, reset         : system clock, synchronous active-high reset
//   tick_1hz           : one-clk pulse per second
//   cur_hour/min/sec   : current time (5/6/6 bits)
//   alarm_hour/min     : alarm time (5/6 bits)
//   alarm_enable       : level, 0 forces DISABLED
//   snooze_btn         : one-clk pulse
//   stop_btn           : one-clk pulse
//   buzzer             : high while the registered state is RINGING
//   alarm_led          : 0 disabled, 1 armed/snoozed, blinks at 1 Hz while ringing
//   state              : DISABLED=0, ARMED=1, RINGING=2, SNOOZED=3
//
// Handshake note: this block has no valid/ready interfaces. Every input is
// sampled on each rising clk edge. The buttons and tick_1hz count as events
// only in the cycle they are high. Every output is registered and changes
// one clock after the input that caused it.
module alarm_controller #(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MAX_SEC = 60,
  parameter int MAX_SNOOZES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_enable,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       alarm_led,
  output logic [1:0] state
);

  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam int RW = $clog2(RING_MAX_SEC + 1);
  localparam int UW = $clog2(MAX_SNOOZES + 1);

  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_MIN * 60);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_MAX_SEC - 1);
  localparam logic [UW-1:0] USED_MAX    = UW'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_ARMED    = 2'd1,
    S_RINGING  = 2'd2,
    S_SNOOZED  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          buzzer_q, buzzer_d;
  logic          led_q, led_d;
  logic          match_q, match_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [UW-1:0] snooze_used_q, snooze_used_d;

  logic match;
  logic trigger;

  // The alarm fires only on the first cycle of the matching second. Enabling
  // the alarm while the time already matches does not ring.
  assign match   = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
  assign trigger = match && !match_q;

  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snooze_cnt_d  = snooze_cnt_q;
    snooze_used_d = snooze_used_q;
    match_d       = match;

    if (!alarm_enable) begin
      state_d = S_DISABLED;
    end else begin
      unique case (state_q)
        S_DISABLED: state_d = S_ARMED;
        S_ARMED: begin
          if (trigger) begin
            state_d    = S_RINGING;
            ring_cnt_d = '0;
          end
        end
        S_RINGING: begin
          // A button event takes priority, and a tick in the same cycle is
          // dropped. A snooze request at the limit is not an event, so a
          // tick in that cycle still counts toward auto-silence.
          if (stop_btn) begin
            state_d = S_ARMED;
          end else if (snooze_btn && (snooze_used_q < USED_MAX)) begin
            state_d       = S_SNOOZED;
            snooze_cnt_d  = SNOOZE_LOAD;
            snooze_used_d = snooze_used_q + UW'(1);
          end else if (tick_1hz) begin
            if (ring_cnt_q == RING_LAST) state_d = S_ARMED;
            else ring_cnt_d = ring_cnt_q + RW'(1);
          end
        end
        S_SNOOZED: begin
          if (stop_btn) begin
            state_d = S_ARMED;
          end else if (tick_1hz) begin
            if (snooze_cnt_q == SW'(1)) begin
              state_d    = S_RINGING;
              ring_cnt_d = '0;
            end else begin
              snooze_cnt_d = snooze_cnt_q - SW'(1);
            end
          end
        end
        default: state_d = S_DISABLED;
      endcase
    end

    // Each new alarm event starts with a fresh snooze allowance.
    if ((state_d == S_ARMED || state_d == S_DISABLED) && (state_d != state_q))
      snooze_used_d = '0;
    if (state_d == S_DISABLED)
      snooze_used_d = '0;
  end

  // The outputs are computed from the next state so that the registered
  // copies stay in step with state_q.
  always_comb begin
    buzzer_d = (state_d == S_RINGING);
    led_d    = 1'b0;
    unique case (state_d)
      S_DISABLED: led_d = 1'b0;
      S_ARMED:    led_d = 1'b1;
      S_SNOOZED:  led_d = 1'b1;
      S_RINGING: begin
        if (state_q != S_RINGING) led_d = 1'b1;          // entry
        else if (tick_1hz && !stop_btn && !snooze_btn) led_d = ~led_q;
        else if (tick_1hz && snooze_btn && !(snooze_used_q < USED_MAX) && !stop_btn)
          led_d = ~led_q;                                // ignored snooze, tick counts
        else led_d = led_q;
      end
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_DISABLED;
      buzzer_q      <= 1'b0;
      led_q         <= 1'b0;
      match_q       <= 1'b0;
      ring_cnt_q    <= '0;
      snooze_cnt_q  <= '0;
      snooze_used_q <= '0;
    end else begin
      state_q       <= state_d;
      buzzer_q      <= buzzer_d;
      led_q         <= led_d;
      match_q       <= match_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_cnt_q  <= snooze_cnt_d;
      snooze_used_q <= snooze_used_d;
    end
  end

  assign buzzer    = buzzer_q;
  assign alarm_led = led_q;
  assign state     = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_enable;
  logic       snooze_btn;
  logic       stop_btn;
  logic       buzzer;
  logic       alarm_led;
  logic [1:0] state;

  int checks_n   = 0;
  int failures_n = 0;

  alarm_controller #(
    .SNOOZE_MIN  (1),
    .RING_MAX_SEC(5),
    .MAX_SNOOZES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .alarm_hour  (alarm_hour),
    .alarm_min   (alarm_min),
    .alarm_enable(alarm_enable),
    .snooze_btn  (snooze_btn),
    .stop_btn    (stop_btn),
    .buzzer      (buzzer),
    .alarm_led   (alarm_led),
    .state       (state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      failures_n++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock. Inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hour = h; cur_min = m; cur_sec = s;
  endtask

  // Step 07:29:59 -> 07:30:00 and expect ringing one clock after the match.
  task automatic ring_up(input string tag);
    set_time(5'd7, 6'd29, 6'd59); step();
    set_time(5'd7, 6'd30, 6'd0);  step();
    check({tag, "_state"}, 32'(state), 32'd2);
    check({tag, "_buzz"}, 32'(buzzer), 32'd1);
    check({tag, "_led"}, 32'(alarm_led), 32'd1);
  endtask

  task automatic wait_snooze(input string tag);
    for (int i = 0; i < 59; i++) pulse_tick();
    check({tag, "_still_snoozed"}, 32'(state), 32'd3);
    pulse_tick();
    check({tag, "_rings_again"}, 32'(state), 32'd2);
    check({tag, "_buzz_again"}, 32'(buzzer), 32'd1);
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    alarm_enable = 1'b0; alarm_hour = 5'd7; alarm_min = 6'd30;
    set_time(5'd6, 6'd0, 6'd0);
    step(); step(); step();
    reset = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_buzz", 32'(buzzer), 32'd0);
    check("rst_led", 32'(alarm_led), 32'd0);

    // 1: ring, then auto-silence after 5 ticks with 4 LED toggles
    alarm_enable = 1'b1; step();
    check("t1_armed", 32'(state), 32'd1);
    check("t1_armed_led", 32'(alarm_led), 32'd1);
    ring_up("t1");
    for (int i = 1; i <= 4; i++) begin
      pulse_tick();
      check("t1_blink_led", 32'(alarm_led), 32'(i % 2 == 0));
      check("t1_still_ring", 32'(state), 32'd2);
    end
    pulse_tick();
    check("t1_silenced", 32'(state), 32'd1);
    check("t1_silenced_buzz", 32'(buzzer), 32'd0);
    check("t1_silenced_led", 32'(alarm_led), 32'd1);

    // 2: snooze, then ring again exactly 60 ticks later
    ring_up("t2");
    pulse_snooze();
    check("t2_snoozed", 32'(state), 32'd3);
    check("t2_snooze_buzz", 32'(buzzer), 32'd0);
    check("t2_snooze_led", 32'(alarm_led), 32'd1);
    wait_snooze("t2");
    // the snooze count reaches the limit of 2 here
    pulse_snooze();
    check("t2_second_snooze", 32'(state), 32'd3);
    wait_snooze("t2b");
    // 3: the third snooze is ignored, stop re-arms, and the next alarm may snooze
    pulse_snooze();
    check("t3_snooze_ignored", 32'(state), 32'd2);
    check("t3_buzz_kept", 32'(buzzer), 32'd1);
    pulse_stop();
    check("t3_stopped", 32'(state), 32'd1);
    check("t3_stopped_buzz", 32'(buzzer), 32'd0);
    ring_up("t3_nextday");
    pulse_snooze();
    check("t3_snooze_allowed", 32'(state), 32'd3);
    pulse_stop();
    check("t3_stop_from_snooze", 32'(state), 32'd1);

    // 4: enabling while the time already matches must not ring
    alarm_enable = 1'b0; set_time(5'd7, 6'd30, 6'd0); step();
    check("t4_disabled", 32'(state), 32'd0);
    alarm_enable = 1'b1; step();
    check("t4_armed", 32'(state), 32'd1);
    step(); step();
    check("t4_no_ring", 32'(state), 32'd1);
    check("t4_no_buzz", 32'(buzzer), 32'd0);

    // 5: stop and snooze together -> armed; disable while snoozed -> disabled
    ring_up("t5");
    stop_btn = 1'b1; snooze_btn = 1'b1; step(); stop_btn = 1'b0; snooze_btn = 1'b0;
    check("t5_stop_wins", 32'(state), 32'd1);
    ring_up("t5b");
    pulse_snooze();
    check("t5_snoozed", 32'(state), 32'd3);
    alarm_enable = 1'b0; step();
    check("t5_disabled", 32'(state), 32'd0);
    check("t5_disabled_led", 32'(alarm_led), 32'd0);

    // 6: reset while ringing
    alarm_enable = 1'b1; step();
    ring_up("t6");
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_state", 32'(state), 32'd0);
    check("t6_buzz", 32'(buzzer), 32'd0);
    check("t6_led", 32'(alarm_led), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
    $finish;
  end

endmodule
